// File: rtl/cache_arbiter.sv
// cache_arbiter: shares one physical-memory port between the L1 I-cache and D-cache.
// Ties go round-robin; the winning command is latched and held downstream until pmem_resp.
module cache_arbiter #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_pmem_read,
  input  logic              i_pmem_write,
  input  logic [ADDR_W-1:0] i_pmem_address,
  input  logic [LINE_W-1:0] i_pmem_wdata,
  output logic              i_pmem_resp,
  output logic [LINE_W-1:0] i_pmem_rdata,
  input  logic              d_pmem_read,
  input  logic              d_pmem_write,
  input  logic [ADDR_W-1:0] d_pmem_address,
  input  logic [LINE_W-1:0] d_pmem_wdata,
  output logic              d_pmem_resp,
  output logic [LINE_W-1:0] d_pmem_rdata,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [ADDR_W-1:0] pmem_address,
  output logic [LINE_W-1:0] pmem_wdata,
  input  logic              pmem_resp,
  input  logic [LINE_W-1:0] pmem_rdata
);

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;
  typedef enum logic [1:0] {OP_NONE, OP_READ, OP_WRITE} op_t;

  localparam logic GRANT_I = 1'b0;
  localparam logic GRANT_D = 1'b1;

  state_t            r_state;
  state_t            w_nextState;
  op_t               r_op;
  op_t               w_selOp;
  logic              r_lastGrant;
  logic [ADDR_W-1:0] r_addr;
  logic [LINE_W-1:0] r_wdata;
  logic              w_iReq;
  logic              w_dReq;
  logic              w_grantI;
  logic              w_grantD;
  logic              w_selWrite;
  logic [ADDR_W-1:0] w_selAddr;
  logic [LINE_W-1:0] w_selWdata;

  assign w_iReq     = i_pmem_read | i_pmem_write;
  assign w_dReq     = d_pmem_read | d_pmem_write;
  assign w_selWrite = w_grantD ? d_pmem_write   : i_pmem_write;
  assign w_selAddr  = w_grantD ? d_pmem_address : i_pmem_address;
  assign w_selWdata = w_grantD ? d_pmem_wdata   : i_pmem_wdata;
  assign w_selOp    = w_selWrite ? OP_WRITE : OP_READ;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Command capture happens only on a grant, so requester changes while busy are invisible
  always_ff @(posedge clk) begin
    if (rst) begin
      r_op        <= OP_NONE;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_lastGrant <= GRANT_I;
    end else if (w_grantI || w_grantD) begin
      r_op        <= w_selOp;
      r_addr      <= w_selAddr;
      r_wdata     <= w_selWdata;
      r_lastGrant <= w_grantD ? GRANT_D : GRANT_I;
    end
  end

  always_comb begin
    w_nextState = r_state;
    w_grantI    = 1'b0;
    w_grantD    = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_iReq && w_dReq) begin
          if (r_lastGrant == GRANT_I) begin
            w_grantD = 1'b1;
          end else begin
            w_grantI = 1'b1;
          end
        end else if (w_iReq) begin
          w_grantI = 1'b1;
        end else if (w_dReq) begin
          w_grantD = 1'b1;
        end
        if (w_grantI) begin
          w_nextState = BUSY_I;
        end else if (w_grantD) begin
          w_nextState = BUSY_D;
        end
      end
      BUSY_I, BUSY_D: begin
        // Always passing through IDLE gives requesters a cycle to drop their command
        if (pmem_resp) begin
          w_nextState = IDLE;
        end
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  always_comb begin
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    i_pmem_resp  = 1'b0;
    d_pmem_resp  = 1'b0;
    pmem_address = r_addr;
    pmem_wdata   = r_wdata;
    i_pmem_rdata = pmem_rdata;
    d_pmem_rdata = pmem_rdata;
    if (r_state == BUSY_I || r_state == BUSY_D) begin
      pmem_read  = (r_op == OP_READ);
      pmem_write = (r_op == OP_WRITE);
    end
    // A reset cycle abandons the transaction, so no completion is reported
    i_pmem_resp = (r_state == BUSY_I) && pmem_resp && !rst;
    d_pmem_resp = (r_state == BUSY_D) && pmem_resp && !rst;
  end

endmodule

// File: tb/tb_cache_arbiter.sv
// tb_cache_arbiter: directed scenarios followed by randomized traffic, all checked
// against a transaction-level reference of who owns the memory port and with what command.
module tb_cache_arbiter;

  localparam int ADDR_W = 32;
  localparam int LINE_W = 256;

  logic              clk = 1'b0;
  logic              rst;
  logic              i_pmem_read, i_pmem_write, i_pmem_resp;
  logic [ADDR_W-1:0] i_pmem_address;
  logic [LINE_W-1:0] i_pmem_wdata, i_pmem_rdata;
  logic              d_pmem_read, d_pmem_write, d_pmem_resp;
  logic [ADDR_W-1:0] d_pmem_address;
  logic [LINE_W-1:0] d_pmem_wdata, d_pmem_rdata;
  logic              pmem_read, pmem_write, pmem_resp;
  logic [ADDR_W-1:0] pmem_address;
  logic [LINE_W-1:0] pmem_wdata, pmem_rdata;

  always #5 clk = ~clk;

  cache_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) dut (
    .clk(clk), .rst(rst),
    .i_pmem_read(i_pmem_read), .i_pmem_write(i_pmem_write),
    .i_pmem_address(i_pmem_address), .i_pmem_wdata(i_pmem_wdata),
    .i_pmem_resp(i_pmem_resp), .i_pmem_rdata(i_pmem_rdata),
    .d_pmem_read(d_pmem_read), .d_pmem_write(d_pmem_write),
    .d_pmem_address(d_pmem_address), .d_pmem_wdata(d_pmem_wdata),
    .d_pmem_resp(d_pmem_resp), .d_pmem_rdata(d_pmem_rdata),
    .pmem_read(pmem_read), .pmem_write(pmem_write),
    .pmem_address(pmem_address), .pmem_wdata(pmem_wdata),
    .pmem_resp(pmem_resp), .pmem_rdata(pmem_rdata)
  );

  int vectors = 0;
  int miscompares = 0;

  // What each cache currently wants from memory
  bit                iPend, iRd, iWr, dPend, dRd, dWr;
  logic [ADDR_W-1:0] iAddr, dAddr;
  logic [LINE_W-1:0] iWd, dWd;

  // Reference: owner 0 = I-cache, 1 = D-cache; clean = nothing latched since reset
  bit                mBusy, mWrite, mClean;
  int                mOwner, mLast;
  logic [ADDR_W-1:0] mAddr;
  logic [LINE_W-1:0] mWd;

  function automatic logic [LINE_W-1:0] randLine();
    logic [LINE_W-1:0] v;
    for (int k = 0; k < LINE_W / 32; k++) v[k*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic checkOutput(input string tag, input logic [LINE_W-1:0] obs, input logic [LINE_W-1:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One clock cycle: drive, check against the reference, then advance the reference
  task automatic applyStimulus(input bit rstV, input bit respV, input logic [LINE_W-1:0] rdataV);
    bit expI, expD, iReq, dReq;
    int win;
    @(negedge clk);
    rst            = rstV;
    pmem_resp      = respV;
    pmem_rdata     = rdataV;
    i_pmem_read    = iPend & iRd;
    i_pmem_write   = iPend & iWr;
    i_pmem_address = iAddr;
    i_pmem_wdata   = iWd;
    d_pmem_read    = dPend & dRd;
    d_pmem_write   = dPend & dWr;
    d_pmem_address = dAddr;
    d_pmem_wdata   = dWd;
    #1;
    expI = mBusy && (mOwner == 0) && respV && !rstV;
    expD = mBusy && (mOwner == 1) && respV && !rstV;
    checkOutput("pmem_read", pmem_read, mBusy && !mWrite);
    checkOutput("pmem_write", pmem_write, mBusy && mWrite);
    if (mBusy || mClean) begin
      checkOutput("pmem_address", pmem_address, mAddr);
      checkOutput("pmem_wdata", pmem_wdata, mWd);
    end
    checkOutput("i_pmem_resp", i_pmem_resp, expI);
    checkOutput("d_pmem_resp", d_pmem_resp, expD);
    if (expI) checkOutput("i_pmem_rdata", i_pmem_rdata, rdataV);
    if (expD) checkOutput("d_pmem_rdata", d_pmem_rdata, rdataV);
    @(posedge clk);
    if (rstV) begin
      mBusy = 0; mLast = 0; mAddr = '0; mWd = '0; mClean = 1;
    end else if (mBusy) begin
      if (respV) mBusy = 0;
    end else begin
      iReq = iPend && (iRd || iWr);
      dReq = dPend && (dRd || dWr);
      if (iReq && dReq) win = (mLast == 0) ? 1 : 0;
      else if (iReq)    win = 0;
      else if (dReq)    win = 1;
      else              win = -1;
      if (win >= 0) begin
        mBusy = 1; mOwner = win; mLast = win; mClean = 0;
        if (win == 0) begin mWrite = iWr; mAddr = iAddr; mWd = iWd; end
        else          begin mWrite = dWr; mAddr = dAddr; mWd = dWd; end
      end
    end
    if (expI) iPend = 0;
    if (expD) dPend = 0;
  endtask

  initial begin
    iPend = 0; iRd = 0; iWr = 0; iAddr = '0; iWd = '0;
    dPend = 0; dRd = 0; dWr = 0; dAddr = '0; dWd = '0;
    rst = 1; pmem_resp = 0; pmem_rdata = '0;
    i_pmem_read = 0; i_pmem_write = 0; i_pmem_address = '0; i_pmem_wdata = '0;
    d_pmem_read = 0; d_pmem_write = 0; d_pmem_address = '0; d_pmem_wdata = '0;
    repeat (2) @(posedge clk);
    mBusy = 0; mWrite = 0; mLast = 0; mOwner = 0; mAddr = '0; mWd = '0; mClean = 1;
    applyStimulus(1, 0, '0);
    applyStimulus(0, 1, randLine());

    $display("[TB] single I read");
    iPend = 1; iRd = 1; iWr = 0; iAddr = 32'h0000_0060; iWd = randLine();
    applyStimulus(0, 0, '0);
    applyStimulus(0, 0, '0);
    applyStimulus(0, 0, '0);
    applyStimulus(0, 1, {32{8'hA5}});
    applyStimulus(0, 1, randLine());

    $display("[TB] tie after reset with command latching");
    applyStimulus(1, 0, '0);
    iPend = 1; iRd = 1; iWr = 0; iAddr = 32'h0000_0100;
    dPend = 1; dRd = 0; dWr = 1; dAddr = 32'h0000_0200; dWd = {8{32'hDEAD_BEEF}};
    applyStimulus(0, 0, '0);
    dAddr = 32'hFFFF_FFE0; iAddr = $urandom; dWd = randLine();
    applyStimulus(0, 0, '0);
    applyStimulus(0, 1, randLine());
    iAddr = 32'h0000_0100;
    applyStimulus(0, 0, '0);
    applyStimulus(0, 0, '0);
    applyStimulus(0, 1, randLine());
    applyStimulus(0, 0, '0);

    $display("[TB] round-robin under continuous demand");
    for (int c = 0; c < 12; c++) begin
      if (!iPend) begin iPend = 1; iRd = 1; iWr = 0; iAddr = $urandom; end
      if (!dPend) begin dPend = 1; dRd = 1; dWr = 0; dAddr = $urandom; end
      applyStimulus(0, (c % 3) == 2, randLine());
    end
    iPend = 0; dPend = 0;
    applyStimulus(0, 1, '0);
    applyStimulus(0, 0, '0);

    $display("[TB] reset mid-transaction");
    applyStimulus(1, 0, '0);
    iPend = 1; iRd = 1; iWr = 0; iAddr = 32'h0000_0440;
    applyStimulus(0, 0, '0);
    applyStimulus(0, 0, '0);
    applyStimulus(1, 0, '0);
    dPend = 1; dRd = 1; dWr = 0; dAddr = 32'h0000_0880;
    applyStimulus(0, 0, '0);
    applyStimulus(0, 0, '0);
    applyStimulus(0, 1, randLine());
    applyStimulus(0, 0, '0);
    applyStimulus(0, 1, randLine());
    applyStimulus(0, 0, '0);

    $display("[TB] D read plus write, stray resp in IDLE");
    dPend = 1; dRd = 1; dWr = 1; dAddr = 32'h0000_0C00; dWd = randLine();
    applyStimulus(0, 0, '0);
    applyStimulus(0, 1, randLine());
    applyStimulus(0, 1, randLine());
    applyStimulus(0, 1, randLine());

    $display("[TB] randomized traffic");
    for (int c = 0; c < 3000; c++) begin
      if (!iPend && ($urandom % 3 == 0)) begin
        iPend = 1; iRd = 1; iWr = ($urandom % 8 == 0);
        iAddr = $urandom; iWd = randLine();
      end
      if (!dPend && ($urandom % 3 == 0)) begin
        dPend = 1;
        case ($urandom % 3)
          0:       begin dRd = 1; dWr = 0; end
          1:       begin dRd = 0; dWr = 1; end
          default: begin dRd = 1; dWr = 1; end
        endcase
        dAddr = $urandom; dWd = randLine();
      end
      if ($urandom % 4 == 0) begin iAddr = $urandom; iWd = randLine(); end
      if ($urandom % 4 == 0) begin dAddr = $urandom; dWd = randLine(); end
      applyStimulus($urandom % 64 == 0, $urandom % 3 == 0, randLine());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/cache_arbiter.md
Name: cache_arbiter

Overview:
- Shares the single physical-memory port between the split L1 instruction cache and data cache.
- Each cache's pmem-side interface connects to one requester port. The downstream port drives main memory or L2.
- Arbitrates with round-robin on ties, latches the winning command, and holds it stable downstream until pmem_resp.
- Routes the response back to the granted requester only.

Parameters:
- ADDR_W, 32, physical address width
- LINE_W, 256, cache line width in bits

Ports:
- clk  in  1  system clock, rising-edge
- rst  in  1  synchronous, active-high reset
- i_pmem_read  in  1  I-cache line read request
- i_pmem_write  in  1  I-cache line write request (normally 0)
- i_pmem_address  in  ADDR_W  I-cache line address
- i_pmem_wdata  in  LINE_W  I-cache write line
- i_pmem_resp  out  1  I-cache completion strobe
- i_pmem_rdata  out  LINE_W  I-cache read line
- d_pmem_read  in  1  D-cache line read request
- d_pmem_write  in  1  D-cache writeback request
- d_pmem_address  in  ADDR_W  D-cache line address
- d_pmem_wdata  in  LINE_W  D-cache writeback line
- d_pmem_resp  out  1  D-cache completion strobe
- d_pmem_rdata  out  LINE_W  D-cache read line
- pmem_read  out  1  downstream read
- pmem_write  out  1  downstream write
- pmem_address  out  ADDR_W  downstream address
- pmem_wdata  out  LINE_W  downstream write line
- pmem_resp  in  1  downstream completion
- pmem_rdata  in  LINE_W  downstream read line

Behaviour:
- Clock and reset: one clock domain; reset is synchronous and active-high. Port names are clk and rst.
- Request definition: a requester is requesting when its pmem_read or pmem_write is high.
  - Requesters hold their command until their resp.
  - If read and write are both high, write takes precedence.
- States: IDLE, BUSY_I, BUSY_D.
- IDLE:
  - pmem_read and pmem_write are 0.
  - When exactly one requester is requesting, latch that requester's op, address and wdata at the clock edge and go to its BUSY state.
  - When both are requesting, grant the one not equal to last_grant, then update last_grant.
  - With no request, stay in IDLE.
- BUSY_x:
  - Drive pmem_read/pmem_write, pmem_address and pmem_wdata from the latched registers only. Requester-side changes are ignored until completion.
  - On pmem_resp=1, assert x_pmem_resp=1 combinationally in the same cycle and go to IDLE at the clock edge.
  - The other requester's resp stays 0.
- Return to IDLE: after every completion there is exactly one IDLE cycle before the next grant. This guarantees requesters have dropped or replaced their command before being resampled.
- Read data: pmem_rdata is broadcast unregistered to both i_pmem_rdata and d_pmem_rdata. Only the resp strobe qualifies it.
- Latency:
  - Request visible in IDLE in cycle N gives a downstream command in cycle N+1.
  - Requester resp occurs in the same cycle as pmem_resp.
  - Minimum transaction is 2 cycles: grant, then resp.
- Unsolicited input: pmem_resp in IDLE is ignored, and no requester resp is generated.
- Reset values:
  - state=IDLE, last_grant=I (so D wins the first tie).
  - Latched op=none, latched address=0, latched wdata=0.
  - All outputs 0: pmem_read, pmem_write, i_pmem_resp, d_pmem_resp, pmem_address, pmem_wdata.
- Reset mid-transaction: abandon the transaction and deassert the downstream command on the next cycle. No resp is issued to either requester.
- Simultaneous pmem_resp and new request from the other requester in BUSY: complete the current transaction. The other requester is arbitrated in the following IDLE cycle.
- Starvation bound: neither requester waits more than one full transaction of the other once it is requesting.

Test Plan:
- Single I read:
  - Stimulus: i_pmem_read=1, addr 0x0000_0060; memory returns line 0xA5..A5 after 3 cycles.
  - Required: pmem_read high from cycle N+1 with pmem_address 0x60; i_pmem_resp is a 1-cycle pulse coincident with pmem_resp, i_pmem_rdata equal to that line; d_pmem_resp stays 0.
- Tie after reset:
  - Stimulus: i read 0x100 and d write 0x200 (wdata 0xDEAD..BEEF) raised in the same cycle.
  - Required: D is served first, with pmem_write=1, address 0x200 and that wdata. After d_pmem_resp, one IDLE cycle, then I read of 0x100.
- Round-robin: both requesters continuously re-request across 4 transactions -> grant order D, I, D, I; no requester is granted twice in a row while the other waits.
- Command latching:
  - Stimulus: during BUSY_D, change d_pmem_address to 0xFFFF_FFE0 and i_pmem_address arbitrarily.
  - Required: pmem_address holds the latched 0x200 until pmem_resp.
- Reset mid-transaction: assert rst in the second BUSY_I cycle -> next cycle pmem_read=0 and state is IDLE; no i_pmem_resp or d_pmem_resp pulse; the next tie grants D.
- Read plus write from D: d_pmem_read=1 and d_pmem_write=1 together -> pmem_write=1, pmem_read=0. A stray pmem_resp in IDLE produces no requester resp.
